mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Multicycle main-memory arbiter and block-fill sequencer for the cached pipeline. It shares one pipelined single-port unified memory between two requesters:
- the I-cache miss handler, which only does block fills;
- the D-cache miss handler, which does block fills and single-word write-through stores.

It issues the eight word addresses of a block on consecutive cycles, steers returned words to the winning requester with a word index, and pulses a done strobe when the transaction completes.

## Interface
Parameters:
- WORDS, 8: 16-bit words per cache block (power of two).
- MEM_LAT, 4: cycles from `mem_en` issue to `mem_valid` return for a read.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: I-side fill request; held until `i_done`.
- `i_addr` in 16: I-side miss byte address.
- `d_req` in 1: D-side request; held until `d_done`.
- `d_we` in 1: D-side request is a single-word write (1) or a fill (0).
- `d_addr` in 16: D-side byte address.
- `d_wdata` in 16: D-side store data.
- `i_grant` out 1: I-side transaction in progress.
- `d_grant` out 1: D-side transaction in progress.
- `i_fill_valid` out 1: `fill_data` is a word for the I-cache.
- `d_fill_valid` out 1: `fill_data` is a word for the D-cache.
- `fill_data` out 16: returned word.
- `fill_idx` out log2(WORDS): word offset within the block.
- `i_done` out 1: one-cycle completion pulse, I-side.
- `d_done` out 1: one-cycle completion pulse, D-side.
- `mem_en` out 1: memory request strobe.
- `mem_wr` out 1: memory write.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_valid` in 1: read data valid.

## Operation
States: IDLE, FILL_I, FILL_D, WRITE_D.

Transitions from IDLE, sampled on the clock edge:
- D request pending takes priority by default (see Configuration).
- `d_req & d_we` → WRITE_D.
- `d_req & ~d_we` → FILL_D.
- else `i_req` → FILL_I.

Fill states:
- Block base = addr with the low log2(WORDS)+1 bits cleared.
- Issue counter k runs 0..WORDS-1. Each cycle drive `mem_en`=1, `mem_wr`=0, `mem_addr` = base + 2k.
- After WORDS issues, `mem_en` drops.
- Return counter increments on each `mem_valid`.
- `fill_idx` = return count, `fill_data` = `mem_rdata`, and the matching `*_fill_valid` = `mem_valid`.
- The matching `*_done` asserts in the same cycle as the final return. The next state is IDLE.

WRITE_D:
- One cycle of `mem_en`=1, `mem_wr`=1, `mem_addr` = `d_addr`, `mem_wdata` = `d_wdata`.
- `d_done`=1 in that cycle. The next state is IDLE.

General rules:
- `*_grant` is high exactly while in that requester's state.
- A request deasserted mid-transaction is ignored; the transaction runs to completion.
- Address and data are sampled at grant and registered, so later changes have no effect.
- `mem_valid` outside FILL states is ignored; no fill strobes are produced.
- Reset mid-transaction → IDLE immediately; counters cleared; no done pulse. The memory shares `rst`, so there are no stale returns.

## Timing
- Reset values: all outputs 0, state IDLE.
- Grant in cycle G = the first cycle in the FILL/WRITE state, which is one cycle after `req` is high in IDLE.
- Fill: word k is issued in cycle G+k and returned in G+k+MEM_LAT. Done is in G+WORDS-1+MEM_LAT, giving a fill occupancy of WORDS+MEM_LAT cycles. The earliest next grant is G+WORDS+MEM_LAT+1.
- Write: issue and done both in cycle G. The earliest next grant is G+2.
- Done pulses are exactly one cycle wide.
- If `req` is still high in IDLE after done, it re-arbitrates; requesters must drop `req` in the cycle after done.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A one-bit last-served register (reset: I) gives round-robin priority when both requests are pending in IDLE.
  - The requester not served last wins.
  - It updates on every grant.
- Undefined: fixed D-over-I priority, and no last-served register exists.

## Test plan
- Reset, then I fill of 0x1236, MEM_LAT=4:
  - addresses 0x1230..0x123E issued on 8 consecutive cycles;
  - `i_fill_valid` with `fill_idx` 0..7 from G+4;
  - `i_done` at G+11 only.
- D write 0x0040 ← 0xBEEF:
  - single cycle `mem_en`=`mem_wr`=1, `mem_addr`=0x0040, `mem_wdata`=0xBEEF;
  - `d_done` in the same cycle;
  - no fill strobes.
- `i_req` and D fill asserted together:
  - fixed mode serves D then I;
  - with `MEM_ARB_RR_EN` after reset, D goes first (last=I); repeated contention alternates.
- `i_req` dropped at G+2: the fill completes all 8 words and `i_done` still pulses.
- `rst` asserted at G+5 of a fill:
  - outputs 0 immediately;
  - no done pulse;
  - the next request is granted normally.
- `mem_valid` pulsed while IDLE: no `*_fill_valid`, and `fill_idx` is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined single-port memory between the I-cache
// fill handler and the D-cache fill/write-through handler. A fill issues
// WORDS consecutive word addresses, steers returned words to the winner
// with a word index, and pulses done on the final return. A D-side write
// is a single-cycle memory write.
//
// Optional feature: define MEM_ARB_RR_EN to give round-robin priority
// under contention (last-served register). Left undefined, D always wins.
module mem_arbiter #(
    parameter int unsigned WORDS   = 8,
    parameter int unsigned MEM_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [15:0]                i_addr,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [15:0]                d_addr,
    input  logic [15:0]                d_wdata,
    output logic                       i_grant,
    output logic                       d_grant,
    output logic                       i_fill_valid,
    output logic                       d_fill_valid,
    output logic [15:0]                fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_idx,
    output logic                       i_done,
    output logic                       d_done,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_wdata,
    input  logic [15:0]                mem_rdata,
    input  logic                       mem_valid
);

    localparam int unsigned IW = $clog2(WORDS);
    // Byte-address bits covering one block (16-bit words, so one extra bit).
    localparam logic [15:0] BASE_MASK = ~16'(2 * WORDS - 1);
    localparam logic [IW:0] ISS_END   = (IW + 1)'(WORDS);
    localparam logic [IW-1:0] RET_LAST = IW'(WORDS - 1);

    // Reject configurations the counters cannot represent.
    if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0) || (MEM_LAT < 1)) begin : g_bad_cfg
        $error("mem_arbiter: WORDS must be a power of two >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_I  = 2'd1,
        FILL_D  = 2'd2,
        WRITE_D = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [IW:0]   iss_q, iss_d;
    logic [IW-1:0] ret_q, ret_d;
    logic          pick_d;
    logic [15:0]   iss_off;

`ifdef MEM_ARB_RR_EN
    // last_q: 1 = D side was granted most recently, 0 = I side.
    logic          last_q, last_d;

    // Under contention the side not served last wins.
    always_comb begin
        pick_d = d_req & (~i_req | ~last_q);
    end

    // Last-served register tracks every grant taken from IDLE.
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE) begin
            if (pick_d) begin
                last_d = 1'b1;
            end else if (i_req) begin
                last_d = 1'b0;
            end
        end
    end

    // Round-robin history, reset to "I served last" so D goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: any pending D request beats the I side.
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Word offset of the next issued address within the block.
    always_comb begin
        iss_off = 16'({iss_q[IW-1:0], 1'b0});
    end

    // State register plus captured address, write data and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state logic and all memory/requester outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        iss_d        = iss_q;
        ret_d        = ret_q;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_data    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                iss_d = '0;
                ret_d = '0;
                if (pick_d) begin
                    wdata_d = d_wdata;
                    if (d_we) begin
                        state_d = WRITE_D;
                        addr_d  = d_addr;
                    end else begin
                        state_d = FILL_D;
                        addr_d  = d_addr & BASE_MASK;
                    end
                end else if (i_req) begin
                    state_d = FILL_I;
                    addr_d  = i_addr & BASE_MASK;
                end
            end

            FILL_I, FILL_D: begin
                i_grant = (state_q == FILL_I);
                d_grant = (state_q == FILL_D);
                // Issue side runs ahead of the return side by MEM_LAT cycles.
                if (iss_q < ISS_END) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q + iss_off;
                    iss_d    = iss_q + {{IW{1'b0}}, 1'b1};
                end
                if (mem_valid) begin
                    fill_data    = mem_rdata;
                    i_fill_valid = (state_q == FILL_I);
                    d_fill_valid = (state_q == FILL_D);
                    ret_d        = ret_q + {{(IW-1){1'b0}}, 1'b1};
                    if (ret_q == RET_LAST) begin
                        i_done  = (state_q == FILL_I);
                        d_done  = (state_q == FILL_D);
                        state_d = IDLE;
                    end
                end
            end

            WRITE_D: begin
                d_grant   = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_done    = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Return count doubles as the word index of the current returned word.
    always_comb begin
        fill_idx = ret_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of transactions plus random
// ones, each checked cycle by cycle against expectations derived from the
// timing rules (issue at G+k, return at G+k+LAT, done on the last return).
// Also defines MEM_ARB_RR_EN-aware arbitration expectations.
module tb_mem_arbiter;

    localparam int W   = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, i_fill_valid, d_fill_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_done, d_done, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;
    logic        force_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    bit last_d = 1'b0;  // model: 1 when D was granted most recently

    mem_arbiter #(.WORDS(W), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .i_done(i_done), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Pipelined memory model with a fixed read latency of LAT cycles.
    logic [LAT-1:0] vld;
    logic [15:0]    adr [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld    <= {vld[LAT-2:0], mem_en & ~mem_wr};
            adr[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) adr[i] <= adr[i-1];
        end
    end
    assign mem_valid = vld[LAT-1] | force_valid;
    assign mem_rdata = vld[LAT-1] ? memf(adr[LAT-1]) : 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner when both sides request in IDLE.
    function automatic bit pick_d_model(input bit ir, input bit dr);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " i_grant"}, i_grant, 0);
        chk({tag, " d_grant"}, d_grant, 0);
        chk({tag, " i_done"}, i_done, 0);
        chk({tag, " d_done"}, d_done, 0);
        chk({tag, " i_fv"}, i_fill_valid, 0);
        chk({tag, " d_fv"}, d_fill_valid, 0);
    endtask

    // Check one granted transaction from cycle G through the following IDLE cycle.
    task automatic serve(input bit side_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wd, input int drop_t, input string tag);
        int n;
        logic [15:0] base;
        n = we ? 1 : W + LAT;
        base = addr & 16'hFFF0;
        last_d = side_d;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            chk({tag, " i_grant"}, i_grant, !side_d);
            chk({tag, " d_grant"}, d_grant, side_d);
            if (we) begin
                chk({tag, " wr mem_en"}, mem_en, 1);
                chk({tag, " wr mem_wr"}, mem_wr, 1);
                chk({tag, " wr mem_addr"}, mem_addr, addr);
                chk({tag, " wr mem_wdata"}, mem_wdata, wd);
                chk({tag, " wr d_done"}, d_done, 1);
                chk({tag, " wr i_done"}, i_done, 0);
                chk({tag, " wr fv"}, {i_fill_valid, d_fill_valid}, 0);
            end else begin
                chk({tag, " mem_en"}, mem_en, t < W);
                if (t < W) begin
                    chk({tag, " mem_wr"}, mem_wr, 0);
                    chk({tag, " mem_addr"}, mem_addr, base + 16'(2 * t));
                end
                chk({tag, " i_fv"}, i_fill_valid, !side_d && t >= LAT);
                chk({tag, " d_fv"}, d_fill_valid, side_d && t >= LAT);
                chk({tag, " fill_idx"}, fill_idx, (t >= LAT) ? t - LAT : 0);
                if (t >= LAT) chk({tag, " fill_data"}, fill_data, memf(base + 16'(2 * (t - LAT))));
                chk({tag, " i_done"}, i_done, !side_d && t == n - 1);
                chk({tag, " d_done"}, d_done, side_d && t == n - 1);
            end
            // Later changes to the winner's inputs must not matter.
            if (t == 0) begin
                if (side_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = !we; d_we = we; end
                else i_addr = $urandom;
            end
            if (t == drop_t) begin
                if (side_d) d_req = 1'b0; else i_req = 1'b0;
            end
        end
        if (side_d) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk);
        chk_quiet({tag, " idle"});
    endtask

    typedef struct {
        bit ir; bit dr; bit dwe;
        logic [15:0] ia; logic [15:0] da; logic [15:0] dwd;
        int drop_i;
    } vec_t;

    task automatic apply(input vec_t v, input string tag);
        bit first_d;
        i_addr = v.ia; d_addr = v.da; d_wdata = v.dwd; d_we = v.dwe;
        i_req = v.ir; d_req = v.dr;
        first_d = pick_d_model(v.ir, v.dr);
        if (first_d) serve(1'b1, v.dwe, v.da, v.dwd, -1, {tag, " D"});
        else         serve(1'b0, 1'b0, v.ia, 16'h0, v.drop_i, {tag, " I"});
        if (v.ir && v.dr) begin
            if (first_d) serve(1'b0, 1'b0, v.ia, 16'h0, v.drop_i, {tag, " I2"});
            else         serve(1'b1, v.dwe, v.da, v.dwd, -1, {tag, " D2"});
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{ir:1, dr:0, dwe:0, ia:16'h1236, da:16'h0000, dwd:16'h0000, drop_i:-1};
        tbl[1] = '{ir:0, dr:1, dwe:1, ia:16'h0000, da:16'h0040, dwd:16'hBEEF, drop_i:-1};
        tbl[2] = '{ir:1, dr:1, dwe:0, ia:16'h3008, da:16'h2000, dwd:16'h0000, drop_i:-1};
        tbl[3] = '{ir:1, dr:1, dwe:0, ia:16'h5550, da:16'h4446, dwd:16'h0000, drop_i:-1};
        tbl[4] = '{ir:1, dr:0, dwe:0, ia:16'h6002, da:16'h0000, dwd:16'h0000, drop_i:2};
        tbl[5] = '{ir:1, dr:1, dwe:1, ia:16'h7770, da:16'h0102, dwd:16'h1234, drop_i:-1};

        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {i_grant, d_grant, i_fill_valid, d_fill_valid, i_done, d_done, mem_en, mem_wr}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset fill_idx", fill_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven transactions, starting with the I fill right after reset.
        for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of a fill.
        i_addr = 16'h0A0A; i_req = 1'b1;
        for (int t = 0; t <= 5; t++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid grant", {i_grant, d_grant}, 0);
        chk("rst mid mem_en", mem_en, 0);
        chk("rst mid mem_addr", mem_addr, 0);
        chk("rst mid done", {i_done, d_done}, 0);
        chk("rst mid fill_idx", fill_idx, 0);
        i_req = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_quiet("rst hold");
        for (int t = 0; t < W + LAT; t++) begin
            @(negedge clk);
            chk_quiet("after rst");
        end

        // mem_valid while IDLE must be ignored.
        force_valid = 1'b1;
        #1;
        chk("idle valid fv", {i_fill_valid, d_fill_valid}, 0);
        chk("idle valid idx", fill_idx, 0);
        @(negedge clk);
        chk("idle valid idx2", fill_idx, 0);
        chk_quiet("idle valid");
        force_valid = 1'b0;
        @(negedge clk);

        // A request after reset is served normally.
        apply(tbl[0], "post rst");

        // Randomized transactions, including contention.
        for (int r = 0; r < 30; r++) begin
            vec_t v;
            v.ir = 1'($urandom); v.dr = 1'($urandom); v.dwe = 1'($urandom);
            if (!v.ir && !v.dr) v.ir = 1'b1;
            v.ia = 16'($urandom); v.da = 16'($urandom); v.dwd = 16'($urandom);
            v.drop_i = int'($urandom_range(0, 12)) - 1;
            apply(v, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
